// File: rtl/serial_divide_unit.sv
// -----------------------------------------------------------------------------
// serial_divide_unit
//
// Multi-cycle integer divider for the Senior execution stage. It computes
// quotient and remainder with one restoring-division step per clock and uses a
// start/busy/done handshake. Signed mode truncates toward zero, and the
// remainder takes the sign of the dividend. Divide-by-zero skips the
// iterations and returns quot = all ones and rem = dividend, with div_zero_o set.
//
// Ports
//   clk_i       : clock, rising edge
//   reset_n_i   : asynchronous active-low reset
//   start_i     : request a division (sampled only in IDLE)
//   signed_i    : 1 = two's-complement, 0 = unsigned (captured with start_i)
//   flush_i     : abort any operation in progress, no done_o
//   op_a_i      : dividend
//   op_b_i      : divisor
//   busy_o      : operation in progress
//   done_o      : one-cycle pulse, results valid
//   quot_o      : quotient, held until next completed operation
//   rem_o       : remainder, held until next completed operation
//   div_zero_o  : divisor was zero, held with the results
//
// State table
//   state | meaning
//   IDLE  | waiting for start_i, busy_o = 0
//   RUN   | one restoring step per cycle, nat_w steps
//   FIX   | sign correction, register results, pulse done_o
// -----------------------------------------------------------------------------
module serial_divide_unit #(
    parameter int nat_w = 16
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             flush_i,
    input  logic [nat_w-1:0] op_a_i,
    input  logic [nat_w-1:0] op_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [nat_w-1:0] quot_o,
    output logic [nat_w-1:0] rem_o,
    output logic             div_zero_o
);

    localparam int cnt_w = (nat_w > 1) ? $clog2(nat_w) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [cnt_w-1:0] cnt;
    logic [nat_w-1:0] dvd_q;     // dividend bits shift out, quotient bits shift in
    logic [nat_w-1:0] dvs_q;     // divisor magnitude
    logic [nat_w-1:0] part_q;    // partial remainder
    logic             q_neg;
    logic             r_neg;
    logic             dz_q;

    // Operand magnitudes. The most negative value maps to itself, which is
    // its correct unsigned magnitude in this datapath.
    logic             a_neg;
    logic             b_neg;
    logic [nat_w-1:0] a_mag;
    logic [nat_w-1:0] b_mag;
    logic             b_zero;

    always_comb begin
        a_neg  = signed_i & op_a_i[nat_w-1];
        b_neg  = signed_i & op_b_i[nat_w-1];
        a_mag  = a_neg ? ('0 - op_a_i) : op_a_i;
        b_mag  = b_neg ? ('0 - op_b_i) : op_b_i;
        b_zero = (op_b_i == '0);
    end

    // One restoring step. The partial remainder is always below the divisor,
    // so the shifted value is below twice the divisor. Bit nat_w of the trial
    // difference is therefore a reliable borrow flag.
    logic [nat_w:0]   shifted;
    logic [nat_w:0]   trial;
    logic             q_bit;
    logic [nat_w-1:0] quot_fix;
    logic [nat_w-1:0] rem_fix;

    always_comb begin
        shifted  = {part_q, dvd_q[nat_w-1]};
        trial    = shifted - {1'b0, dvs_q};
        q_bit    = ~trial[nat_w];
        quot_fix = q_neg ? ('0 - dvd_q) : dvd_q;
        rem_fix  = r_neg ? ('0 - part_q) : part_q;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= IDLE;
            cnt        <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            part_q     <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            dz_q       <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            quot_o     <= '0;
            rem_o      <= '0;
            div_zero_o <= 1'b0;
        end else if (flush_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        busy_o <= 1'b1;
                        dz_q   <= b_zero;
                        part_q <= '0;
                        if (b_zero) begin
                            // The raw dividend is kept so that it can be returned
                            // as the remainder.
                            dvd_q <= op_a_i;
                            dvs_q <= '0;
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                            state <= FIX;
                        end else begin
                            dvd_q <= a_mag;
                            dvs_q <= b_mag;
                            q_neg <= a_neg ^ b_neg;
                            r_neg <= a_neg;
                            cnt   <= cnt_w'(nat_w - 1);
                            state <= RUN;
                        end
                    end
                end

                RUN: begin
                    part_q <= q_bit ? trial[nat_w-1:0] : shifted[nat_w-1:0];
                    dvd_q  <= {dvd_q[nat_w-2:0], q_bit};
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                FIX: begin
                    if (dz_q) begin
                        quot_o <= '1;
                        rem_o  <= dvd_q;
                    end else begin
                        quot_o <= quot_fix;
                        rem_o  <= rem_fix;
                    end
                    div_zero_o <= dz_q;
                    done_o     <= 1'b1;
                    busy_o     <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
